// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the MIPS decode stage:
//   - opcodes of the branches resolved in Decode
//   - forward-select encoding for the two branch-operand muxes
//   - idex_t: the register-index / valid part of the ID/EX payload. The data
//     words of that payload live in the top level, because their width is
//     the module parameter DATA_W and a package cannot see it.
// ----------------------------------------------------------------------------
package decode_pkg;

    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    // 2'b11 is not a member on purpose: it selects the register file,
    // same as FWD_RF, and is handled by the default arm of the muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_M  = 2'b01,
        FWD_W  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       valid;
    } idex_t;

endpackage

// File: rtl/reg_file_bp.sv
// ----------------------------------------------------------------------------
// reg_file_bp
// 32 x DATA_W register file with two combinational read ports, one write
// port and optional write-through bypass. r0 always reads zero and ignores
// writes. Reset clears every register.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   we, wa, wd        write enable / address / data (written on rising edge)
//   ra1, ra2          read addresses
//   rd1, rd2          read data (returns wd when bypass applies)
// ----------------------------------------------------------------------------
module reg_file_bp #(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [32];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge, independent of statement order.
    // NOTE: this memory is reset on purpose: the decode stage must read zeros
    // from every register after reset, so it cannot map to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        // NOTE: outputs get a default before any condition so every path
        // assigns them and no latch is inferred.
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (BYPASS_EN && we && (wa != 5'd0)) begin
            if (wa == ra1) rd1 = wd;
            if (wa == ra2) rd2 = wd;
        end
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end

endmodule

// File: rtl/decode_stage_v2.sv
// ----------------------------------------------------------------------------
// decode_stage_v2
// Decode stage of the pipelined MIPS core: IF/ID register, register file with
// bypass, branch resolution with forwarding, branch/jump target generation,
// and the ID/EX register. DATA_W must be at least 32.
//
// Ports:
//   clkD, rstD                  clock, asynchronous active-high reset
//   instrF, PCPlus4F            fetch-stage instruction and PC+4
//   StallD/ClearD               hold / bubble the IF/ID register
//   StallE/FlushE               hold / bubble the ID/EX register
//   ForwardAD/ForwardBD         branch operand select (see fwd_sel_e)
//   AluOutM, ResultW            forwarding sources
//   WriteRegW, RegWriteW        register-file write port (data = ResultW)
//   OPCode, Funct, RsD, RtD     decoded fields of the IF/ID instruction
//   BranchTakenD                resolved branch, qualified by ValidD
//   PCBranchD, PCJumpD          branch and jump targets
//   RD1E..RdE, ValidE           ID/EX register outputs
// ----------------------------------------------------------------------------
module decode_stage_v2
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BYPASS_EN  = 1'b1,
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic              clkD,
    input  logic              rstD,
    input  logic [31:0]       instrF,
    input  logic [DATA_W-1:0] PCPlus4F,
    input  logic              StallD,
    input  logic              ClearD,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [1:0]        ForwardAD,
    input  logic [1:0]        ForwardBD,
    input  logic [DATA_W-1:0] AluOutM,
    input  logic [DATA_W-1:0] ResultW,
    input  logic [4:0]        WriteRegW,
    input  logic              RegWriteW,
    output logic [5:0]        OPCode,
    output logic [5:0]        Funct,
    output logic [4:0]        RsD,
    output logic [4:0]        RtD,
    output logic              BranchTakenD,
    output logic [DATA_W-1:0] PCBranchD,
    output logic [DATA_W-1:0] PCJumpD,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [4:0]        RsE,
    output logic [4:0]        RtE,
    output logic [4:0]        RdE,
    output logic              ValidE
);

    // IF/ID state
    logic [31:0]       instr_d;
    logic [DATA_W-1:0] pc_plus4_d;
    logic              valid_d;

    // decode datapath
    logic [4:0]        rd_d;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] sign_imm_d;
    logic              branch_cond;

    // ID/EX state
    logic [DATA_W-1:0] rd1_e;
    logic [DATA_W-1:0] rd2_e;
    logic [DATA_W-1:0] sign_imm_e;
    idex_t             tag_e;

    // ------------------------------------------------------------------ IF/ID
    always_ff @(posedge clkD or posedge rstD) begin
        if (rstD) begin
            instr_d    <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (ClearD) begin
            instr_d    <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (!StallD) begin
            instr_d    <= instrF;
            pc_plus4_d <= PCPlus4F;
            valid_d    <= 1'b1;
        end
    end

    assign OPCode = instr_d[31:26];
    assign RsD    = instr_d[25:21];
    assign RtD    = instr_d[20:16];
    assign rd_d   = instr_d[15:11];
    assign Funct  = instr_d[5:0];

    // ---------------------------------------------------------- register file
    reg_file_bp #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_reg_file (
        .clk (clkD),
        .rst (rstD),
        .we  (RegWriteW),
        .wa  (WriteRegW),
        .wd  (ResultW),
        .ra1 (RsD),
        .ra2 (RtD),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

    // ------------------------------------------------------- forwarding muxes
    always_comb begin
        fwd_a = rf_rd1;
        case (ForwardAD)
            FWD_M:   fwd_a = AluOutM;
            FWD_W:   fwd_a = ResultW;
            default: fwd_a = rf_rd1;
        endcase
    end

    always_comb begin
        fwd_b = rf_rd2;
        case (ForwardBD)
            FWD_M:   fwd_b = AluOutM;
            FWD_W:   fwd_b = ResultW;
            default: fwd_b = rf_rd2;
        endcase
    end

    // -------------------------------------------------------- branch compare
    // BLEZ/BGTZ test the sign bit and zero-ness of A directly rather than a
    // signed magnitude compare against a literal.
    always_comb begin
        branch_cond = 1'b0;
        case (OPCode)
            OP_BEQ:  branch_cond = (fwd_a == fwd_b);
            OP_BNE:  branch_cond = BRANCH_EXT && (fwd_a != fwd_b);
            OP_BLEZ: branch_cond = BRANCH_EXT && (fwd_a[DATA_W-1] || (fwd_a == '0));
            OP_BGTZ: branch_cond = BRANCH_EXT && !fwd_a[DATA_W-1] && (fwd_a != '0);
            default: branch_cond = 1'b0;
        endcase
    end

    // A cleared IF/ID entry decodes as sll r0 and must never redirect fetch.
    assign BranchTakenD = branch_cond && valid_d;

    // ------------------------------------------------------ immediate/targets
    assign sign_imm_d = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
    assign PCBranchD  = pc_plus4_d + (sign_imm_d << 2);
    assign PCJumpD    = {pc_plus4_d[DATA_W-1:28], instr_d[25:0], 2'b00};

    // ------------------------------------------------------------------ ID/EX
    // RD1E/RD2E take the forwarded operands, so Execute sees the same values
    // the branch compare used.
    always_ff @(posedge clkD or posedge rstD) begin
        if (rstD) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            sign_imm_e <= '0;
            tag_e      <= '0;
        end else if (FlushE) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            sign_imm_e <= '0;
            tag_e      <= '0;
        end else if (!StallE) begin
            rd1_e      <= fwd_a;
            rd2_e      <= fwd_b;
            sign_imm_e <= sign_imm_d;
            tag_e      <= '{rs: RsD, rt: RtD, rd: rd_d, valid: valid_d};
        end
    end

    assign RD1E     = rd1_e;
    assign RD2E     = rd2_e;
    assign SignImmE = sign_imm_e;
    assign RsE      = tag_e.rs;
    assign RtE      = tag_e.rt;
    assign RdE      = tag_e.rd;
    assign ValidE   = tag_e.valid;

endmodule

// File: tb/tb_decode_stage_v2.sv
// ----------------------------------------------------------------------------
// tb_decode_stage_v2
// Three instances share one stimulus stream:
//   u_a : BYPASS_EN=1, BRANCH_EXT=1
//   u_b : BYPASS_EN=0, BRANCH_EXT=1
//   u_c : BYPASS_EN=1, BRANCH_EXT=0
// A behavioural model (register array, plain arithmetic) predicts all
// outputs; a negedge process compares every cycle. A directed prologue pins
// specific cases to hand-computed literals, then randomized traffic runs.
// Inputs change 1 ns after the rising edge; outputs are sampled at negedge.
// ----------------------------------------------------------------------------
module tb_decode_stage_v2;

    localparam int W = 32;

    localparam logic [31:0] I_ADD_R4_R3_R3 = 32'h0063_2020;
    localparam logic [31:0] I_ADD_R5       = 32'h00A0_0000;
    localparam logic [31:0] I_BEQ_R1_R2_4  = 32'h1022_0004;
    localparam logic [31:0] I_BEQ_R0_R0_1  = 32'h1000_0001;
    localparam logic [31:0] I_BLEZ_R6      = 32'h18C0_0000;
    localparam logic [31:0] I_BGTZ_R0      = 32'h1C00_0000;
    localparam logic [31:0] I_BGTZ_R7      = 32'h1CE0_0000;
    localparam logic [31:0] I_J_100        = 32'h0800_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus
    logic          rstD;
    logic [31:0]   instrF;
    logic [W-1:0]  PCPlus4F;
    logic          StallD, ClearD, StallE, FlushE;
    logic [1:0]    ForwardAD, ForwardBD;
    logic [W-1:0]  AluOutM, ResultW;
    logic [4:0]    WriteRegW;
    logic          RegWriteW;

    // instance outputs
    logic [5:0]   a_OPCode, b_OPCode, c_OPCode;
    logic [5:0]   a_Funct, b_Funct, c_Funct;
    logic [4:0]   a_RsD, b_RsD, c_RsD, a_RtD, b_RtD, c_RtD;
    logic         a_BranchTakenD, b_BranchTakenD, c_BranchTakenD;
    logic [W-1:0] a_PCBranchD, b_PCBranchD, c_PCBranchD;
    logic [W-1:0] a_PCJumpD, b_PCJumpD, c_PCJumpD;
    logic [W-1:0] a_RD1E, b_RD1E, c_RD1E, a_RD2E, b_RD2E, c_RD2E;
    logic [W-1:0] a_SignImmE, b_SignImmE, c_SignImmE;
    logic [4:0]   a_RsE, b_RsE, c_RsE, a_RtE, b_RtE, c_RtE, a_RdE, b_RdE, c_RdE;
    logic         a_ValidE, b_ValidE, c_ValidE;

    decode_stage_v2 #(.DATA_W(W), .BYPASS_EN(1'b1), .BRANCH_EXT(1'b1)) u_a (
        .clkD(clk), .rstD(rstD), .instrF(instrF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .ClearD(ClearD), .StallE(StallE), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .AluOutM(AluOutM), .ResultW(ResultW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .OPCode(a_OPCode), .Funct(a_Funct), .RsD(a_RsD), .RtD(a_RtD),
        .BranchTakenD(a_BranchTakenD), .PCBranchD(a_PCBranchD), .PCJumpD(a_PCJumpD),
        .RD1E(a_RD1E), .RD2E(a_RD2E), .SignImmE(a_SignImmE),
        .RsE(a_RsE), .RtE(a_RtE), .RdE(a_RdE), .ValidE(a_ValidE));

    decode_stage_v2 #(.DATA_W(W), .BYPASS_EN(1'b0), .BRANCH_EXT(1'b1)) u_b (
        .clkD(clk), .rstD(rstD), .instrF(instrF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .ClearD(ClearD), .StallE(StallE), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .AluOutM(AluOutM), .ResultW(ResultW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .OPCode(b_OPCode), .Funct(b_Funct), .RsD(b_RsD), .RtD(b_RtD),
        .BranchTakenD(b_BranchTakenD), .PCBranchD(b_PCBranchD), .PCJumpD(b_PCJumpD),
        .RD1E(b_RD1E), .RD2E(b_RD2E), .SignImmE(b_SignImmE),
        .RsE(b_RsE), .RtE(b_RtE), .RdE(b_RdE), .ValidE(b_ValidE));

    decode_stage_v2 #(.DATA_W(W), .BYPASS_EN(1'b1), .BRANCH_EXT(1'b0)) u_c (
        .clkD(clk), .rstD(rstD), .instrF(instrF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .ClearD(ClearD), .StallE(StallE), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .AluOutM(AluOutM), .ResultW(ResultW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .OPCode(c_OPCode), .Funct(c_Funct), .RsD(c_RsD), .RtD(c_RtD),
        .BranchTakenD(c_BranchTakenD), .PCBranchD(c_PCBranchD), .PCJumpD(c_PCJumpD),
        .RD1E(c_RD1E), .RD2E(c_RD2E), .SignImmE(c_SignImmE),
        .RsE(c_RsE), .RtE(c_RtE), .RdE(c_RdE), .ValidE(c_ValidE));

    // ------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [31:0] m_rf [32];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_e_rd1, m_e_rd2, m_e_simm, m_nb_rd1, m_nb_rd2;
    logic [4:0]  m_e_rs, m_e_rt, m_e_rd;
    logic        m_e_valid;

    // expected combinational values of the current cycle
    logic [31:0] e_a, e_b, e_a_nb, e_b_nb, e_simm, e_pcbr, e_pcj;
    logic        e_taken, e_taken_nb, e_taken_nx;
    // snapshot of expected registered outputs of the current cycle
    logic [31:0] p_rd1e, p_rd2e, p_nb_rd1e;
    logic        p_valide;
    shortint     s16;

    function automatic logic [31:0] rf_read(input logic [4:0] addr, input bit bypass);
        if (addr == 0) return 32'h0;
        if (bypass && RegWriteW && WriteRegW == addr) return ResultW;
        return m_rf[addr];
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf_val);
        if (sel == 2'd1) return AluOutM;
        if (sel == 2'd2) return ResultW;
        return rf_val;
    endfunction

    function automatic logic take(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit ext, input logic valid);
        int sa;
        logic t;
        sa = $signed(a);
        case (op)
            6'd4:    t = (a == b);
            6'd5:    t = ext && (a != b);
            6'd6:    t = ext && (sa <= 0);
            6'd7:    t = ext && (sa > 0);
            default: t = 1'b0;
        endcase
        return t && valid;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_e_rd1 = 0; m_e_rd2 = 0; m_e_simm = 0; m_nb_rd1 = 0; m_nb_rd2 = 0;
        m_e_rs = 0; m_e_rt = 0; m_e_rd = 0; m_e_valid = 0;
    endtask

    always @(negedge clk) begin
        if (rstD) model_reset();

        e_a    = pick(ForwardAD, rf_read(m_instr[25:21], 1'b1));
        e_b    = pick(ForwardBD, rf_read(m_instr[20:16], 1'b1));
        e_a_nb = pick(ForwardAD, rf_read(m_instr[25:21], 1'b0));
        e_b_nb = pick(ForwardBD, rf_read(m_instr[20:16], 1'b0));
        s16    = m_instr[15:0];
        e_simm = int'(s16);
        e_pcbr = m_pc4 + e_simm * 4;
        e_pcj  = (m_pc4 & 32'hF000_0000) | (32'(m_instr[25:0]) << 2);
        e_taken    = take(m_instr[31:26], e_a, e_b, 1'b1, m_valid);
        e_taken_nb = take(m_instr[31:26], e_a_nb, e_b_nb, 1'b1, m_valid);
        e_taken_nx = take(m_instr[31:26], e_a, e_b, 1'b0, m_valid);
        p_rd1e = m_e_rd1; p_rd2e = m_e_rd2; p_nb_rd1e = m_nb_rd1; p_valide = m_e_valid;

        check("opcode", 32'(a_OPCode), 32'(m_instr[31:26]));
        check("funct", 32'(a_Funct), 32'(m_instr[5:0]));
        check("rsd", 32'(a_RsD), 32'(m_instr[25:21]));
        check("rtd", 32'(a_RtD), 32'(m_instr[20:16]));
        check("taken", 32'(a_BranchTakenD), 32'(e_taken));
        check("pcbranch", a_PCBranchD, e_pcbr);
        check("pcjump", a_PCJumpD, e_pcj);
        check("rd1e", a_RD1E, m_e_rd1);
        check("rd2e", a_RD2E, m_e_rd2);
        check("signimme", a_SignImmE, m_e_simm);
        check("rse", 32'(a_RsE), 32'(m_e_rs));
        check("rte", 32'(a_RtE), 32'(m_e_rt));
        check("rde", 32'(a_RdE), 32'(m_e_rd));
        check("valide", 32'(a_ValidE), 32'(m_e_valid));
        check("nb_taken", 32'(b_BranchTakenD), 32'(e_taken_nb));
        check("nb_rd1e", b_RD1E, m_nb_rd1);
        check("nb_rd2e", b_RD2E, m_nb_rd2);
        check("nx_taken", 32'(c_BranchTakenD), 32'(e_taken_nx));

        // advance the model across the coming rising edge
        if (!rstD) begin
            if (FlushE) begin
                m_e_rd1 = 0; m_e_rd2 = 0; m_e_simm = 0; m_nb_rd1 = 0; m_nb_rd2 = 0;
                m_e_rs = 0; m_e_rt = 0; m_e_rd = 0; m_e_valid = 0;
            end else if (!StallE) begin
                m_e_rd1 = e_a; m_e_rd2 = e_b; m_e_simm = e_simm;
                m_nb_rd1 = e_a_nb; m_nb_rd2 = e_b_nb;
                m_e_rs = m_instr[25:21]; m_e_rt = m_instr[20:16]; m_e_rd = m_instr[15:11];
                m_e_valid = m_valid;
            end
            if (ClearD) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!StallD) begin
                m_instr = instrF; m_pc4 = PCPlus4F; m_valid = 1;
            end
            if (RegWriteW && WriteRegW != 0) m_rf[WriteRegW] = ResultW;
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic idle();
        instrF = 0; PCPlus4F = 0; StallD = 0; ClearD = 0; StallE = 0; FlushE = 0;
        ForwardAD = 0; ForwardBD = 0; AluOutM = 0; ResultW = 0; WriteRegW = 0; RegWriteW = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] r, r2;
        int          k;
        logic [5:0]  op;

        idle();
        rstD = 1'b1;
        cyc(); cyc();
        at_sample();
        check("rst_valide", 32'(a_ValidE), 32'h0);
        check("rst_rd1e", a_RD1E, 32'h0);
        check("rst_opcode", 32'(a_OPCode), 32'h0);
        check("rst_pcbranch", a_PCBranchD, 32'h0);
        cyc();
        rstD = 1'b0;

        // bypass: r3 <= 0x11, then r3 <= 0xAA in the cycle add r4,r3,r3 decodes
        instrF = I_ADD_R4_R3_R3; RegWriteW = 1; WriteRegW = 5'd3; ResultW = 32'h11;
        cyc();
        instrF = 0; ResultW = 32'hAA;
        cyc();
        RegWriteW = 0;
        at_sample();
        check("byp_rd1e", a_RD1E, 32'hAA);
        check("byp_rd2e", a_RD2E, 32'hAA);
        check("nobyp_rd1e", b_RD1E, 32'h11);
        check("nobyp_rd2e", b_RD2E, 32'h11);
        check("model_byp_rd1e", p_rd1e, 32'hAA);
        check("model_nobyp_rd1e", p_nb_rd1e, 32'h11);

        // beq r1,r2,+4 with r1=5, r2=0, B forwarded from AluOutM=5
        cyc();
        instrF = I_BEQ_R1_R2_4; PCPlus4F = 32'h100; RegWriteW = 1; WriteRegW = 5'd1; ResultW = 32'd5;
        cyc();
        RegWriteW = 0; ForwardBD = 2'b01; AluOutM = 32'd5; instrF = 0;
        at_sample();
        check("beq_taken", 32'(a_BranchTakenD), 32'h1);
        check("beq_pcbranch", a_PCBranchD, 32'h110);
        check("model_beq_taken", 32'(e_taken), 32'h1);
        check("model_beq_pcbranch", e_pcbr, 32'h110);

        // BLEZ / BGTZ, with and without the extended compares
        cyc();
        ForwardBD = 0; instrF = I_BLEZ_R6;
        cyc();
        ForwardAD = 2'b01; AluOutM = 32'h8000_0000; instrF = I_BGTZ_R0;
        at_sample();
        check("blez_neg_taken", 32'(a_BranchTakenD), 32'h1);
        check("blez_noext", 32'(c_BranchTakenD), 32'h0);
        check("model_blez", 32'(e_taken), 32'h1);
        cyc();
        ForwardAD = 2'b00; instrF = I_BGTZ_R7;
        at_sample();
        check("bgtz_zero", 32'(a_BranchTakenD), 32'h0);
        cyc();
        ForwardAD = 2'b01; AluOutM = 32'd1; instrF = 0;
        at_sample();
        check("bgtz_pos", 32'(a_BranchTakenD), 32'h1);
        check("bgtz_noext", 32'(c_BranchTakenD), 32'h0);

        // ClearD + StallD together on an always-taken branch
        cyc();
        ForwardAD = 0; instrF = I_BEQ_R0_R0_1;
        cyc();
        instrF = 0; ClearD = 1; StallD = 1;
        at_sample();
        check("beq00_taken", 32'(a_BranchTakenD), 32'h1);
        cyc();
        ClearD = 0; StallD = 0;
        at_sample();
        check("clear_taken", 32'(a_BranchTakenD), 32'h0);
        check("clear_opcode", 32'(a_OPCode), 32'h0);

        // StallE holds RD1E, FlushE (together with StallE) zeroes it
        cyc();
        instrF = I_ADD_R4_R3_R3;
        cyc();
        instrF = 0;
        cyc();
        StallE = 1; ForwardAD = 2'b01; AluOutM = 32'h55;
        at_sample();
        check("prestall_rd1e", a_RD1E, 32'hAA);
        for (int i = 0; i < 3; i++) begin
            cyc();
            at_sample();
            check("stall_rd1e", a_RD1E, 32'hAA);
            check("stall_valide", 32'(a_ValidE), 32'h1);
        end
        cyc();
        FlushE = 1;
        cyc();
        FlushE = 0; StallE = 0; ForwardAD = 0;
        at_sample();
        check("flush_rd1e", a_RD1E, 32'h0);
        check("flush_valide", 32'(a_ValidE), 32'h0);
        check("model_flush_valide", 32'(p_valide), 32'h0);

        // jump target
        cyc();
        PCPlus4F = 32'h1000_0004; instrF = I_J_100;
        cyc();
        at_sample();
        check("jump_target", a_PCJumpD, 32'h1000_0400);
        check("model_jump_target", e_pcj, 32'h1000_0400);

        // reset mid-stream clears r5 and the pipeline registers
        cyc();
        RegWriteW = 1; WriteRegW = 5'd5; ResultW = 32'h1234; instrF = I_ADD_R5;
        cyc();
        RegWriteW = 0;
        cyc();
        at_sample();
        check("prerst_rd1e", a_RD1E, 32'h1234);
        cyc();
        rstD = 1;
        at_sample();
        check("midrst_rd1e", a_RD1E, 32'h0);
        check("midrst_valide", 32'(a_ValidE), 32'h0);
        check("midrst_rsd", 32'(a_RsD), 32'h0);
        cyc();
        rstD = 0;
        cyc(); cyc();
        at_sample();
        check("r5_after_rst", a_RD1E, 32'h0);

        // randomized traffic, small register indices to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            cyc();
            r  = $urandom();
            r2 = $urandom();
            k  = $urandom_range(0, 7);
            case (k)
                0:       op = 6'd0;
                1:       op = 6'd4;
                2:       op = 6'd5;
                3:       op = 6'd6;
                4:       op = 6'd7;
                5:       op = 6'd2;
                default: op = r2[5:0];
            endcase
            instrF = {op, r[25:0]};
            instrF[25:24] = 2'b00;
            instrF[20:19] = 2'b00;
            PCPlus4F  = $urandom();
            ForwardAD = 2'($urandom_range(0, 3));
            ForwardBD = 2'($urandom_range(0, 3));
            AluOutM   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            ResultW   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
            WriteRegW = 5'($urandom_range(0, 7));
            RegWriteW = 1'($urandom_range(0, 1));
            StallD    = ($urandom_range(0, 7) == 0);
            ClearD    = ($urandom_range(0, 9) == 0);
            StallE    = ($urandom_range(0, 7) == 0);
            FlushE    = ($urandom_range(0, 9) == 0);
            rstD      = ($urandom_range(0, 299) == 0);
        end
        cyc();
        idle();
        rstD = 0;
        at_sample();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
